// File: rtl/matmul_job_ctrl_if.sv
// rtl/matmul_job_ctrl_if.sv - operand/result streams and engine handshake for matmul_job_ctrl
interface matmul_job_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;

  logic                     eng_start;
  logic                     eng_done;
  logic [4*DATA_W-1:0]      eng_a_flat;
  logic [4*DATA_W-1:0]      eng_b_flat;
  logic [4*ACC_W-1:0]       eng_c_flat;

  // slave: the job controller; master: the operand source, result sink and engine
  modport slave (
    input  in_valid, in_data, out_ready, eng_done, eng_c_flat,
    output in_ready, out_valid, out_data, out_last, eng_start, eng_a_flat, eng_b_flat
  );

  modport master (
    output in_valid, in_data, out_ready, eng_done, eng_c_flat,
    input  in_ready, out_valid, out_data, out_last, eng_start, eng_a_flat, eng_b_flat
  );
endinterface

// File: rtl/matmul_job_ctrl.sv
// rtl/matmul_job_ctrl.sv - collects 2x2 A/B operands, runs the multiply engine, drains C
module matmul_job_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  matmul_job_ctrl_if.slave    bus,
  output logic                busy,
  output logic                err_timeout,
  input  logic                clr_err,
  output logic [15:0]         jobs_done
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [2:0]                idx;
  logic [2:0]                idx_nxt;
  logic [15:0]               wait_cnt;
  logic [15:0]               wait_cnt_nxt;
  logic signed [DATA_W-1:0]  opnd [0:7];
  logic signed [ACC_W-1:0]   res  [0:3];
  logic [15:0]               jobs_cnt;
  logic                      err_q;

  logic                      in_ready;
  logic                      out_valid;
  logic                      eng_start;
  logic                      in_fire;
  logic                      capture;
  logic                      timeout_hit;
  logic                      job_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_cnt_nxt = '0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    eng_start    = 1'b0;
    in_fire      = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    job_fire     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          in_fire = 1'b1;
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = START;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      START: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // a completion on the final allowed cycle still counts as success
        if (bus.eng_done) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = LOAD;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (idx == 3'd3) begin
            job_fire  = 1'b1;
            idx_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) opnd[k] <= '0;
    end else if (in_fire) begin
      opnd[idx] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) res[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < 4; k++) res[k] <= bus.eng_c_flat[k*ACC_W +: ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      jobs_cnt <= '0;
    end else begin
      // a timeout in the same cycle as clr_err leaves the flag set
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
      if (job_fire) jobs_cnt <= jobs_cnt + 16'd1;
    end
  end

  always_comb begin
    bus.eng_a_flat = '0;
    bus.eng_b_flat = '0;
    for (int k = 0; k < 4; k++) begin
      bus.eng_a_flat[k*DATA_W +: DATA_W] = opnd[k];
      bus.eng_b_flat[k*DATA_W +: DATA_W] = opnd[k+4];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.eng_start = eng_start;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = res[idx[1:0]];
  assign bus.out_last  = out_valid && (idx == 3'd3);
  assign busy          = (state != LOAD) || (idx != 3'd0);
  assign err_timeout   = err_q;
  assign jobs_done     = jobs_cnt;

endmodule

// File: tb/tb_matmul_job_ctrl.sv
// tb/tb_matmul_job_ctrl.sv - table-driven jobs with result scoreboard for matmul_job_ctrl
module tb_matmul_job_ctrl;
  localparam int DATA_W      = 8;
  localparam int ACC_W       = 32;
  localparam int TIMEOUT_CYC = 64;

  typedef struct packed {
    logic [7:0][7:0]  ops;
    logic [3:0][31:0] ex;
    logic             stall;
  } vec_t;

  typedef struct packed {
    logic signed [31:0] data;
    logic               last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_err = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic [15:0] jobs_done;

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];
  vec_t vecs[5];

  int rdy_mode  = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int outv_cnt  = 0;
  bit prev_stall = 1'b0;
  logic signed [ACC_W-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  int eng_delay = 3;
  bit eng_en    = 1'b1;
  bit spur      = 1'b0;
  int ecnt      = 0;

  always #5 clk = ~clk;

  matmul_job_ctrl_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus();

  matmul_job_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .err_timeout(err_timeout),
    .clr_err(clr_err),
    .jobs_done(jobs_done)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [4*ACC_W-1:0] eng_model(input logic [4*DATA_W-1:0] a, input logic [4*DATA_W-1:0] b);
    logic [4*ACC_W-1:0] c;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 2; k++)
          s += $signed(a[(2*i+k)*DATA_W +: DATA_W]) * $signed(b[(2*k+j)*DATA_W +: DATA_W]);
        c[(2*i+j)*ACC_W +: ACC_W] = s;
      end
    end
    return c;
  endfunction

  // engine model: done pulse eng_delay cycles into WAIT; optional stray done strobes
  always @(negedge clk) begin
    bus.eng_done = 1'b0;
    if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) begin
        bus.eng_done   = 1'b1;
        bus.eng_c_flat = eng_model(bus.eng_a_flat, bus.eng_b_flat);
      end
    end
    if (bus.eng_start && eng_en) ecnt = eng_delay;
    if (spur && (bus.in_ready || bus.out_valid)) begin
      bus.eng_done   = 1'b1;
      bus.eng_c_flat = {4{32'h5A5A_5A5A}};
    end
  end

  // result sink and scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    bus.out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    if (bus.eng_start) start_cnt++;
    if (bus.out_valid) begin
      outv_cnt++;
      check("in_ready_drain", bus.in_ready, 0);
      if (prev_stall) begin
        check("stall_data", bus.out_data, prev_data);
        check("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=%0d required=none", bus.out_data);
        end else begin
          e = sbq.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
        end
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
  end

  task automatic send(input logic [7:0] v);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", (t < 200), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [7:0][7:0] ops, input logic [3:0][31:0] ex, input bit want, input int n);
    if (want)
      for (int k = 0; k < 4; k++) sbq.push_back(exp_t'{data: ex[k], last: (k == 3)});
    for (int k = 0; k < n; k++) send(ops[k]);
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_idle"}, (t < 400), 1);
    if (t >= 400) sbq.delete();
  endtask

  task automatic timeout_job(input bit clr_on_hit);
    int n = 0;
    int ov = outv_cnt;
    logic [15:0] j = jobs_done;
    eng_en = 1'b0;
    run_job(vecs[0].ops, vecs[0].ex, 1'b0, 8);
    while (n < 300) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == TIMEOUT_CYC) check("err_before_limit", err_timeout, 0);
      if (clr_on_hit && n == TIMEOUT_CYC + 1) clr_err = 1'b1;
    end
    clr_err = 1'b0;
    check("timeout_cycles", n, TIMEOUT_CYC + 1);
    check("err_set", err_timeout, 1);
    check("timeout_no_output", outv_cnt - ov, 0);
    check("timeout_jobs", jobs_done, j);
    eng_en = 1'b1;
  endtask

  initial begin
    int exp_jobs;
    int s0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs[0] = '{ops: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                ex: {32'sd50, 32'sd43, 32'sd22, 32'sd19}, stall: 1'b0};
    vecs[1] = '{ops: {8'hF9, 8'h05, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h00, 8'hFF},
                ex: {32'sd7, -32'sd5, -32'sd127, 32'sd128}, stall: 1'b0};
    vecs[2] = '{ops: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                ex: {32'sd50, 32'sd43, 32'sd22, 32'sd19}, stall: 1'b1};
    vecs[3] = '{ops: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0, 8'd0, 8'd2},
                ex: {32'sd12, 32'sd10, 32'sd8, 32'sd6}, stall: 1'b0};
    vecs[4] = '{ops: {8{8'h80}}, ex: {4{32'sd32768}}, stall: 1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_jobs", jobs_done, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_a_flat", bus.eng_a_flat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_jobs = 0;
    for (int i = 0; i < 5; i++) begin
      rdy_mode = int'(vecs[i].stall);
      s0 = start_cnt;
      run_job(vecs[i].ops, vecs[i].ex, 1'b1, 8);
      wait_idle("table");
      exp_jobs++;
      check("jobs_done", jobs_done, exp_jobs);
      check("start_pulses", start_cnt - s0, 1);
    end
    rdy_mode = 0;

    timeout_job(1'b0);
    run_job(vecs[3].ops, vecs[3].ex, 1'b1, 8);
    wait_idle("after_timeout");
    exp_jobs++;
    check("jobs_after_timeout", jobs_done, exp_jobs);
    check("err_sticky", err_timeout, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("err_cleared", err_timeout, 0);

    eng_delay = TIMEOUT_CYC;
    run_job(vecs[0].ops, vecs[0].ex, 1'b1, 8);
    wait_idle("done_at_limit");
    exp_jobs++;
    check("limit_jobs", jobs_done, exp_jobs);
    check("limit_no_err", err_timeout, 0);
    eng_delay = 3;

    timeout_job(1'b1);

    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_load_busy", busy, 0);
    check("spur_load_ready", bus.in_ready, 1);
    rdy_mode = 1;
    run_job(vecs[3].ops, vecs[3].ex, 1'b1, 8);
    wait_idle("spur");
    exp_jobs++;
    check("spur_jobs", jobs_done, exp_jobs);
    spur = 1'b0;
    rdy_mode = 0;

    @(negedge clk);
    force dut.jobs_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_cnt;
    run_job(vecs[1].ops, vecs[1].ex, 1'b1, 8);
    wait_idle("wrap");
    check("jobs_wrap", jobs_done, 0);

    run_job(vecs[3].ops, vecs[3].ex, 1'b0, 5);
    @(negedge clk);
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_timeout, 0);
    check("mid_rst_jobs", jobs_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(vecs[0].ops, vecs[0].ex, 1'b1, 8);
    wait_idle("after_reset");
    check("jobs_after_reset", jobs_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end
endmodule
